aes_state_manager: RTL and testbench

- Moore control FSM for an iterative AES-128 encryption core.
- Sequences plaintext load, key load, wait for key expansion, 10 rounds (SubBytes, ShiftRows, MixColumns, AddRoundKey; MixColumns skipped in round 9), then ciphertext readout.
- Drives the 4x4 state-matrix port (row/column select, index, read/write, write enable, input-mux select).
- Exposes current state and round for debug.

---
 rtl/aes_state_manager.sv | 157 +++++++++++++++
 tb/tb_aes_state_manager.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/aes_state_manager.sv
// Purpose: Moore control FSM sequencing an iterative AES-128 core (load, key wait, 10 rounds, readout).
// Latency: start accept to SUBBYTES = 9 cycles with keys ready; rounds 0..8 take 16 cycles, round 9 takes 12.
// Backpressure: waits indefinitely in COMPUTE_ROUNDKEYS for key_expand_done and in ENCRYPTION_DONE for start_read_n.
//
// Ports:
//   clock, reset_n                      - rising-edge clock, asynchronous active-low reset
//   start_write_n, start_read_n         - active-low start strobes, honoured only in IDLE / ENCRYPTION_DONE
//   key_expand_done                     - all round keys available
//   done                                - high while ciphertext is ready
//   dbg_state, dbg_round                - current state code and round for debug
//   matrix_in_sel, matrix_write_enable  - state-matrix write-data mux select and write strobe
//   mat_row_col, mat_read_write, mat_idx - matrix access mode (0 row/1 col), direction (0 rd/1 wr), index
module aes_state_manager (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start_write_n,
  input  logic       start_read_n,
  input  logic       key_expand_done,
  output logic       done,
  output logic [5:0] dbg_state,
  output logic [3:0] dbg_round,
  output logic [3:0] matrix_in_sel,
  output logic       matrix_write_enable,
  output logic       mat_row_col,
  output logic       mat_read_write,
  output logic [1:0] mat_idx
);

  typedef enum logic [5:0] {
    IDLE              = 6'd0,
    PLAINTEXT_WRITE   = 6'd1,
    KEY_WRITE         = 6'd2,
    COMPUTE_ROUNDKEYS = 6'd3,
    SUBBYTES          = 6'd4,
    SHIFTROWS         = 6'd5,
    MIXCOLUMNS        = 6'd6,
    ADDROUNDKEY       = 6'd7,
    ENCRYPTION_DONE   = 6'd8,
    CIPHERTEXT_READ   = 6'd9
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'd9;

  state_t     state;
  logic [3:0] round;
  logic [1:0] step;
  logic       last_step;

  assign last_step = (step == 2'd3);

  // Multi-step states advance the step counter and leave on step 3; step
  // is always cleared together with a state change.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      round <= 4'd0;
      step  <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          step <= 2'd0;
          if (!start_write_n) begin
            state <= PLAINTEXT_WRITE;
            round <= 4'd0;
          end
        end
        PLAINTEXT_WRITE: begin
          step <= step + 2'd1;
          if (last_step) state <= KEY_WRITE;
        end
        KEY_WRITE: begin
          step <= step + 2'd1;
          if (last_step) state <= COMPUTE_ROUNDKEYS;
        end
        COMPUTE_ROUNDKEYS: begin
          step <= 2'd0;
          if (key_expand_done) state <= SUBBYTES;
        end
        SUBBYTES: begin
          step <= step + 2'd1;
          if (last_step) state <= SHIFTROWS;
        end
        SHIFTROWS: begin
          step <= step + 2'd1;
          // Final round has no MixColumns.
          if (last_step) state <= (round == LAST_ROUND) ? ADDROUNDKEY : MIXCOLUMNS;
        end
        MIXCOLUMNS: begin
          step <= step + 2'd1;
          if (last_step) state <= ADDROUNDKEY;
        end
        ADDROUNDKEY: begin
          step <= step + 2'd1;
          if (last_step) begin
            if (round == LAST_ROUND) begin
              state <= ENCRYPTION_DONE;
            end else begin
              state <= SUBBYTES;
              round <= round + 4'd1;
            end
          end
        end
        ENCRYPTION_DONE: begin
          step <= 2'd0;
          if (!start_read_n) state <= CIPHERTEXT_READ;
        end
        CIPHERTEXT_READ: begin
          step <= step + 2'd1;
          if (last_step) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          step  <= 2'd0;
        end
      endcase
    end
  end

  // Pure decode of registered state/round/step: no input reaches an output.
  always_comb begin
    matrix_in_sel       = 4'd0;
    matrix_write_enable = 1'b0;
    mat_row_col         = 1'b0;
    mat_read_write      = 1'b0;
    case (state)
      PLAINTEXT_WRITE: begin
        matrix_in_sel = 4'd1; matrix_write_enable = 1'b1; mat_row_col = 1'b1; mat_read_write = 1'b1;
      end
      KEY_WRITE: begin
        // Key goes to the key register; matrix only sees column reads.
        matrix_in_sel = 4'd2; mat_row_col = 1'b1;
      end
      SUBBYTES: begin
        matrix_in_sel = 4'd3; matrix_write_enable = 1'b1; mat_row_col = 1'b1; mat_read_write = 1'b1;
      end
      SHIFTROWS: begin
        matrix_in_sel = 4'd4; matrix_write_enable = 1'b1; mat_read_write = 1'b1;
      end
      MIXCOLUMNS: begin
        matrix_in_sel = 4'd5; matrix_write_enable = 1'b1; mat_row_col = 1'b1; mat_read_write = 1'b1;
      end
      ADDROUNDKEY: begin
        matrix_in_sel = 4'd6; matrix_write_enable = 1'b1; mat_row_col = 1'b1; mat_read_write = 1'b1;
      end
      CIPHERTEXT_READ: begin
        mat_row_col = 1'b1;
      end
      default: ;
    endcase
  end

  assign done      = (state == ENCRYPTION_DONE);
  assign dbg_state = state;
  assign dbg_round = round;
  assign mat_idx   = step;

endmodule

// File: tb/tb_aes_state_manager.sv
// Purpose: directed self-checking bench for aes_state_manager.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: drives key_expand_done and start strobes directly.
module tb_aes_state_manager;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start_write_n = 1'b1;
  logic       start_read_n = 1'b1;
  logic       key_expand_done = 1'b0;
  logic       done;
  logic [5:0] dbg_state;
  logic [3:0] dbg_round;
  logic [3:0] matrix_in_sel;
  logic       matrix_write_enable;
  logic       mat_row_col;
  logic       mat_read_write;
  logic [1:0] mat_idx;

  int compared = 0;
  int mismatched = 0;

  aes_state_manager dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .start_write_n       (start_write_n),
    .start_read_n        (start_read_n),
    .key_expand_done     (key_expand_done),
    .done                (done),
    .dbg_state           (dbg_state),
    .dbg_round           (dbg_round),
    .matrix_in_sel       (matrix_in_sel),
    .matrix_write_enable (matrix_write_enable),
    .mat_row_col         (mat_row_col),
    .mat_read_write      (mat_read_write),
    .mat_idx             (mat_idx)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Check all matrix outputs at once, packed as {in_sel, we, rc, rw}.
  task automatic check_mat(input string tag, input logic [3:0] sel, input logic we,
                           input logic rc, input logic rw);
    check(tag, {1'b0, matrix_in_sel, matrix_write_enable, mat_row_col, mat_read_write},
          {1'b0, sel, we, rc, rw});
  endtask

  // Expect a 4-cycle state with given decode; leaves the bench 1 cycle past step 3.
  task automatic phase(input string tag, input logic [5:0] st, input logic [3:0] rnd,
                       input logic [3:0] sel, input logic we, input logic rc, input logic rw);
    for (int i = 0; i < 4; i++) begin
      check({tag, "_state"}, {2'b0, dbg_state}, {2'b0, st});
      check({tag, "_round"}, {4'b0, dbg_round}, {4'b0, rnd});
      check({tag, "_idx"}, {6'b0, mat_idx}, i[7:0]);
      check_mat({tag, "_mat"}, sel, we, rc, rw);
      check({tag, "_done"}, {7'b0, done}, 8'd0);
      tick();
    end
  endtask

  task automatic run_round(input logic [3:0] rnd);
    phase("sub", 6'd4, rnd, 4'd3, 1'b1, 1'b1, 1'b1);
    phase("shr", 6'd5, rnd, 4'd4, 1'b1, 1'b0, 1'b1);
    if (rnd != 4'd9) phase("mix", 6'd6, rnd, 4'd5, 1'b1, 1'b1, 1'b1);
    phase("ark", 6'd7, rnd, 4'd6, 1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    // Reset held
    #12;
    check("rst_state", {2'b0, dbg_state}, 8'd0);
    check("rst_round", {4'b0, dbg_round}, 8'd0);
    check("rst_done", {7'b0, done}, 8'd0);
    check_mat("rst_mat", 4'd0, 1'b0, 1'b0, 1'b0);
    check("rst_idx", {6'b0, mat_idx}, 8'd0);

    // Release; idle with starts high
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("idle_hold", {2'b0, dbg_state}, 8'd0);

    // Load: one-cycle start pulse
    start_write_n = 1'b0;
    tick();
    start_write_n = 1'b1;
    phase("pt", 6'd1, 4'd0, 4'd1, 1'b1, 1'b1, 1'b1);
    phase("key", 6'd2, 4'd0, 4'd2, 1'b0, 1'b1, 1'b0);

    // Key expansion wait
    for (int i = 0; i < 20; i++) begin
      check("kexp_wait", {2'b0, dbg_state}, 8'd3);
      tick();
    end
    check_mat("kexp_mat", 4'd0, 1'b0, 1'b0, 1'b0);
    key_expand_done = 1'b1;
    tick();

    // Full 10-round trace
    for (int r = 0; r < 10; r++) run_round(r[3:0]);

    // Encryption done: holds; stray write start ignored
    start_write_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("edone_state", {2'b0, dbg_state}, 8'd8);
      check("edone_done", {7'b0, done}, 8'd1);
      check("edone_round", {4'b0, dbg_round}, 8'd9);
      tick();
    end
    start_write_n = 1'b1;
    check_mat("edone_mat", 4'd0, 1'b0, 1'b0, 1'b0);

    // Readout
    start_read_n = 1'b0;
    tick();
    start_read_n = 1'b1;
    phase("ctr", 6'd9, 4'd9, 4'd0, 1'b0, 1'b1, 1'b0);
    check("post_read_state", {2'b0, dbg_state}, 8'd0);
    check("post_read_done", {7'b0, done}, 8'd0);

    // Spurious read start in IDLE is ignored
    start_read_n = 1'b0;
    tick();
    tick();
    check("spur_read", {2'b0, dbg_state}, 8'd0);

    // Both starts low in IDLE: write wins. Keys already ready -> 1-cycle wait.
    start_write_n = 1'b0;
    tick();
    start_write_n = 1'b1;
    start_read_n = 1'b1;
    check("both_low", {2'b0, dbg_state}, 8'd1);
    check("both_low_round", {4'b0, dbg_round}, 8'd0);
    for (int i = 0; i < 8; i++) tick();
    check("kexp_fast", {2'b0, dbg_state}, 8'd3);
    tick();
    check("kexp_fast_sub", {2'b0, dbg_state}, 8'd4);
    for (int r = 0; r < 5; r++) run_round(r[3:0]);
    phase("sub5", 6'd4, 4'd5, 4'd3, 1'b1, 1'b1, 1'b1);
    phase("shr5", 6'd5, 4'd5, 4'd4, 1'b1, 1'b0, 1'b1);
    tick();
    check("abort_pre_state", {2'b0, dbg_state}, 8'd6);
    check("abort_pre_idx", {6'b0, mat_idx}, 8'd1);

    // Asynchronous abort mid-MIXCOLUMNS, away from any clock edge
    #1;
    reset_n = 1'b0;
    #1;
    check("abort_state", {2'b0, dbg_state}, 8'd0);
    check("abort_round", {4'b0, dbg_round}, 8'd0);
    check("abort_idx", {6'b0, mat_idx}, 8'd0);
    check_mat("abort_mat", 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    reset_n = 1'b1;
    tick();
    check("abort_idle", {2'b0, dbg_state}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
